regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Buffered register-bank writeback queue with busy scoreboard; WB_FORWARD_EN adds bypass data outputs.
// Latency: accepted write reaches the bank one edge later at the earliest; req_ready drops only when full.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_data,
  input  logic        drain_en,
  output logic        w_en,
  output logic [4:0]  r_write,
  output logic [31:0] w_data,
  input  logic [4:0]  r_op_a,
  input  logic [4:0]  r_op_b,
  output logic        busy_a,
  output logic        busy_b
`ifdef WB_FORWARD_EN
  ,
  output logic [31:0] fwd_a_data,
  output logic [31:0] fwd_b_data
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx;
  logic          push;
  logic          pop;

  // rst is folded in so nothing handshakes while reset is held
  assign req_ready = !rst && (count_q != FULL);
  // index 0 is the hardwired-zero register: accepted but never buffered
  assign push      = req_valid && req_ready && (req_rd != 5'd0);
  assign w_en      = (count_q != '0) && drain_en;
  assign pop       = w_en;
  assign r_write   = (count_q != '0) ? rd_q[head_q]   : 5'd0;
  assign w_data    = (count_q != '0) ? data_q[head_q] : 32'd0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + AW'(1);
    end
    if (push) begin
      tail_d = tail_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= req_rd;
      data_q[tail_q] <= req_data;
    end
  end

  // Walk oldest to youngest so the last match leaves the youngest data
  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    idx    = '0;
`ifdef WB_FORWARD_EN
    fwd_a_data = 32'd0;
    fwd_b_data = 32'd0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (CW'(i) < count_q) begin
        if ((r_op_a != 5'd0) && (rd_q[idx] == r_op_a)) begin
          busy_a = 1'b1;
`ifdef WB_FORWARD_EN
          fwd_a_data = data_q[idx];
`endif
        end
        if ((r_op_b != 5'd0) && (rd_q[idx] == r_op_b)) begin
          busy_b = 1'b1;
`ifdef WB_FORWARD_EN
          fwd_b_data = data_q[idx];
`endif
        end
      end
    end
  end

endmodule
